// File: rtl/sliced_comparator_if.sv
// sliced_comparator_if: request/result bundle between a requester and the sliced comparator
interface sliced_comparator_if #(parameter int WIDTH = 8);
  logic start;
  logic is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic greater;
  logic equal;
  logic less;
  modport master (output start, is_signed, a, b, input busy, done, greater, equal, less);
  modport slave (input start, is_signed, a, b, output busy, done, greater, equal, less);
endinterface

// File: rtl/sliced_comparator.sv
// sliced_comparator: compares two operands SLICE bits per cycle, MSB slice first.
// Define CMP_EARLY_EXIT_EN to finish on the first differing slice instead of scanning all slices.
module sliced_comparator #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic clk,
  input  logic rst_n,
  sliced_comparator_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam logic [1:0] IDLE = 2'd0, CMP = 2'd1, DONE = 2'd2;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef CMP_EARLY_EXIT_EN
  localparam logic EARLY = 1'b1;
`else
  localparam logic EARLY = 1'b0;
`endif
  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("WIDTH must be a multiple of SLICE");
  end
  logic [1:0] state, nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0] idx;
  logic dec, gt_q, gr_q, eq_q, ls_q;
  logic [SLICE-1:0] sa, sb;
  logic diff, a_gt, last, accept, fin, res_diff, res_gt;
  assign sa = a_q[idx*SLICE +: SLICE];
  assign sb = b_q[idx*SLICE +: SLICE];
  assign diff = sa != sb;
  assign a_gt = sa > sb;
  assign last = idx == '0;
  assign accept = bus.start && state != CMP;
  assign fin = state == CMP && (last || (EARLY && diff));
  // an already-decided higher slice wins over anything seen in lower slices
  assign res_diff = dec | diff;
  assign res_gt = dec ? gt_q : a_gt;
  always_comb begin
    nxt = state == IDLE ? (bus.start ? CMP : IDLE) :
          state == CMP  ? (fin ? DONE : CMP) :
                          (bus.start ? CMP : IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      dec <= 1'b0;
      gt_q <= 1'b0;
      gr_q <= 1'b0;
      eq_q <= 1'b0;
      ls_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        // offset-binary: flipping the sign bit makes signed order match unsigned order
        a_q <= bus.is_signed ? bus.a ^ MSB : bus.a;
        b_q <= bus.is_signed ? bus.b ^ MSB : bus.b;
        idx <= IW'(NSLICE - 1);
        dec <= 1'b0;
        gt_q <= 1'b0;
      end else if (state == CMP) begin
        idx <= last ? idx : idx - 1'b1;
        if (diff && !dec) begin
          dec <= 1'b1;
          gt_q <= a_gt;
        end
      end
      if (fin) begin
        gr_q <= res_diff & res_gt;
        eq_q <= ~res_diff;
        ls_q <= res_diff & ~res_gt;
      end
    end
  end
  assign bus.busy = state == CMP;
  assign bus.done = state == DONE;
  assign bus.greater = gr_q;
  assign bus.equal = eq_q;
  assign bus.less = ls_q;
endmodule

// File: tb/tb_sliced_comparator.sv
// tb_sliced_comparator: table, random and hand-written sequences for WIDTH=8 with SLICE=2 and SLICE=8.
module tb_sliced_comparator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sliced_comparator_if #(.WIDTH(8)) i0 ();
  sliced_comparator_if #(.WIDTH(8)) i1 ();
  sliced_comparator #(.WIDTH(8), .SLICE(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  sliced_comparator #(.WIDTH(8), .SLICE(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
  logic [4:0] o0, o1;
  assign o0 = {i0.busy, i0.done, i0.greater, i0.equal, i0.less};
  assign o1 = {i1.busy, i1.done, i1.greater, i1.equal, i1.less};
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    bit s;
    logic [2:0] gel;
    int ln;
    int le;
  } vec_t;
  vec_t tbl[8];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic logic [2:0] ref_gel(input logic [7:0] a, input logic [7:0] b, input bit s);
    int ia, ib;
    ia = s ? int'($signed(a)) : int'(a);
    ib = s ? int'($signed(b)) : int'(b);
    return {ia > ib, ia == ib, ia < ib};
  endfunction
  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input bit s, input int ns);
    int sl, m;
    int ua, ub;
    sl = 8 / ns;
    m = (1 << sl) - 1;
    ua = s ? int'(a ^ 8'h80) : int'(a);
    ub = s ? int'(b ^ 8'h80) : int'(b);
    if (!EE) return ns + 1;
    for (int k = ns - 1; k >= 0; k--)
      if (((ua >> (k * sl)) & m) != ((ub >> (k * sl)) & m)) return 1 + ns - k;
    return ns + 1;
  endfunction
  task automatic run(input bit sel, input logic [7:0] a, input logic [7:0] b, input bit s,
                     input int lat, input logic [2:0] gel, input string nm);
    logic [4:0] o;
    bit seen;
    int got;
    seen = 0;
    got = 0;
    if (sel) begin
      i1.start = 1'b1; i1.a = a; i1.b = b; i1.is_signed = s;
    end else begin
      i0.start = 1'b1; i0.a = a; i0.b = b; i0.is_signed = s;
    end
    @(posedge clk);
    #1;
    i0.start = 1'b0;
    i1.start = 1'b0;
    i0.a = 8'($urandom); i0.b = 8'($urandom); i0.is_signed = 1'($urandom);
    i1.a = 8'($urandom); i1.b = 8'($urandom); i1.is_signed = 1'($urandom);
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      o = sel ? o1 : o0;
      if (c == 1) chk({nm, " busy"}, int'(o[4]), 1);
      if (o[3]) begin
        seen = 1;
        got = c;
        chk({nm, " result"}, int'(o[2:0]), int'(gel));
      end
    end
    chk({nm, " latency"}, got, lat);
    @(negedge clk);
    o = sel ? o1 : o0;
    chk({nm, " idle after done"}, int'(o[4:3]), 0);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] ra, rb;
    bit rs;
    int dn, dc;
    i0.start = 0; i0.a = 0; i0.b = 0; i0.is_signed = 0;
    i1.start = 0; i1.a = 0; i1.b = 0; i1.is_signed = 0;
    tbl[0] = '{8'hA6, 8'h66, 1'b0, 3'b100, 5, 2};
    tbl[1] = '{8'h22, 8'h22, 1'b0, 3'b010, 5, 5};
    tbl[2] = '{8'h4A, 8'h4B, 1'b0, 3'b001, 5, 5};
    tbl[3] = '{8'h80, 8'h7F, 1'b1, 3'b001, 5, 2};
    tbl[4] = '{8'h80, 8'h7F, 1'b0, 3'b100, 5, 2};
    tbl[5] = '{8'hFF, 8'h00, 1'b1, 3'b001, 5, 2};
    tbl[6] = '{8'h10, 8'h20, 1'b0, 3'b001, 5, 3};
    tbl[7] = '{8'hF0, 8'hF3, 1'b1, 3'b001, 5, 5};
    repeat (3) @(negedge clk);
    chk("reset outputs u0", int'(o0), 0);
    chk("reset outputs u1", int'(o1), 0);
    rst_n = 1'b1;
    run(0, 8'hA6, 8'h66, 1'b0, EE ? 2 : 5, 3'b100, "first after reset");
    for (int i = 0; i < 8; i++)
      run(0, tbl[i].a, tbl[i].b, tbl[i].s, EE ? tbl[i].le : tbl[i].ln, tbl[i].gel, $sformatf("vec%0d", i));
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      rs = 1'($urandom);
      run(0, ra, rb, rs, ref_lat(ra, rb, rs, 4), ref_gel(ra, rb, rs), $sformatf("rand%0d", i));
    end
    run(1, 8'h01, 8'h00, 1'b0, 2, 3'b100, "nslice1 gt");
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom);
      rb = (i % 3 == 0) ? ra : 8'($urandom);
      rs = 1'($urandom);
      run(1, ra, rb, rs, ref_lat(ra, rb, rs, 1), ref_gel(ra, rb, rs), $sformatf("nslice1 rand%0d", i));
    end
    // start pulse while busy must neither restart nor recapture
    i0.start = 1; i0.a = 8'h22; i0.b = 8'h22; i0.is_signed = 0;
    @(posedge clk);
    #1 i0.start = 0;
    dn = 0;
    dc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (o0[3]) begin dn++; dc = c; end
      if (c == 5) chk("ignored start flags", int'(o0[2:0]), 3'b010);
      i0.start = (c == 2);
      i0.a = 8'h4A;
      i0.b = 8'h4B;
    end
    i0.start = 0;
    chk("ignored start done count", dn, 1);
    chk("ignored start done cycle", dc, 5);
    // start held high through DONE gives a back-to-back compare
    i0.start = 1; i0.a = 8'h22; i0.b = 8'h22; i0.is_signed = 0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) begin i0.a = 8'h4A; i0.b = 8'h4B; end
      if (c == 5) chk("b2b first done", int'(o0[3:0]), 4'b1010);
      if (c == 6) chk("b2b busy no gap", int'(o0[4]), 1);
      if (c == 6) i0.start = 0;
      if (c == 7) chk("b2b flags held", int'(o0[2:0]), 3'b010);
      if (c == 10) chk("b2b second done", int'(o0[3:0]), 4'b1001);
      if (c == 11) chk("b2b idle", int'(o0[4:3]), 0);
    end
    // reset in the middle of a comparison
    i0.start = 1; i0.a = 8'h4A; i0.b = 8'h4B; i0.is_signed = 0;
    @(posedge clk);
    #1 i0.start = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("mid-cmp reset outputs", int'(o0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o0[3] || o0[4]) dn++;
    end
    chk("no done after reset", dn, 0);
    run(0, 8'h4A, 8'h4B, 1'b0, 5, 3'b001, "after reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
